// File: rtl/lab_pkg.sv
// lab_pkg: LAB4 sample, window and pedestal-sum types shared by the calibration RAM and subtract stages.
package lab_pkg;
    localparam int LAB4_BITS = 12;
    localparam int ADR_BITS = 12;
    localparam int WINDOW = 4096;
    localparam int SUM_BITS = 27;
    localparam int PED_SHIFT = 4;
    localparam logic [LAB4_BITS-1:0] OFFSET_DEFAULT = 12'd2048;
    typedef logic [LAB4_BITS-1:0] sample_t;
    typedef logic [ADR_BITS-1:0] addr_t;
    typedef logic [SUM_BITS-1:0] sum_t;
    typedef logic [LAB4_BITS:0] ped_t;
endpackage

// File: rtl/lab_pedestal_subtract_if.sv
// lab_pedestal_subtract_if: sample stream, pedestal RAM read port and output stream of the subtract stage.
// Optional clip_count_o exists only with LAB_PEDSUB_CLIP_COUNT_EN.
interface lab_pedestal_subtract_if;
    import lab_pkg::*;
    sample_t lab_dat_i;
    logic lab_wr_i;
    logic addr_rst_i;
    logic pedsub_en_i;
    sample_t offset_i;
    addr_t ped_adr_o;
    logic ped_en_o;
    sum_t ped_dat_i;
    sample_t dat_o;
    logic dat_valid_o;
    logic frame_o;
    logic clip_o;
`ifdef LAB_PEDSUB_CLIP_COUNT_EN
    logic [15:0] clip_count_o;
`endif
    modport master(
        output lab_dat_i, lab_wr_i, addr_rst_i, pedsub_en_i, offset_i, ped_dat_i,
        input ped_adr_o, ped_en_o, dat_o, dat_valid_o, frame_o, clip_o
`ifdef LAB_PEDSUB_CLIP_COUNT_EN
        , input clip_count_o
`endif
    );
    modport slave(
        input lab_dat_i, lab_wr_i, addr_rst_i, pedsub_en_i, offset_i, ped_dat_i,
        output ped_adr_o, ped_en_o, dat_o, dat_valid_o, frame_o, clip_o
`ifdef LAB_PEDSUB_CLIP_COUNT_EN
        , output clip_count_o
`endif
    );
endinterface

// File: rtl/lab_sat_sub.sv
// lab_sat_sub: combinational sample - pedestal + offset, saturated to the unsigned sample range.
module lab_sat_sub
    import lab_pkg::*;
(
    input sample_t sample,
    input ped_t ped,
    input sample_t offset,
    output sample_t dat,
    output logic clip
);
    logic signed [LAB4_BITS+2:0] diff;
    assign diff = $signed({3'b0, sample}) - $signed({2'b0, ped}) + $signed({3'b0, offset});
    assign clip = diff[LAB4_BITS+2] || (|diff[LAB4_BITS+1:LAB4_BITS]);
    assign dat = diff[LAB4_BITS+2] ? '0 : (clip ? '1 : diff[LAB4_BITS-1:0]);
endmodule

// File: rtl/lab_pedestal_subtract.sv
// lab_pedestal_subtract: two-stage pedestal subtraction of the LAB4 stream against the calibration RAM.
// LAB_PEDSUB_CLIP_COUNT_EN adds a per-window saturating clip counter on clip_count_o.
module lab_pedestal_subtract
    import lab_pkg::*;
(
    input logic sys_clk_i,
    input logic rst_i,
    lab_pedestal_subtract_if.slave bus
);
    addr_t cnt, adr;
    sample_t act_off, s1_dat, sat_dat;
    logic s1_valid, s1_last, s1_en, sat_clip;
    ped_t ped;

    // addr_rst_i forces address 0 for a coincident strobe as well as an idle reset
    assign adr = bus.addr_rst_i ? '0 : cnt;
    assign bus.ped_adr_o = adr;
    assign bus.ped_en_o = bus.lab_wr_i;
    assign ped = ped_t'(bus.ped_dat_i >> PED_SHIFT);

    lab_sat_sub u_sat (.sample(s1_dat), .ped(ped), .offset(act_off), .dat(sat_dat), .clip(sat_clip));

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            act_off <= OFFSET_DEFAULT;
            s1_valid <= 1'b0;
            s1_dat <= '0;
            s1_last <= 1'b0;
            s1_en <= 1'b0;
            bus.dat_o <= '0;
            bus.dat_valid_o <= 1'b0;
            bus.frame_o <= 1'b0;
            bus.clip_o <= 1'b0;
        end else begin
            cnt <= bus.lab_wr_i ? adr + 1'b1 : adr;
            s1_valid <= bus.lab_wr_i;
            if (bus.lab_wr_i) begin
                s1_dat <= bus.lab_dat_i;
                s1_last <= &adr;
                s1_en <= bus.pedsub_en_i;
            end
            // the address-0 sample reaches S2 one edge later, so it already sees its own offset
            if (bus.lab_wr_i && adr == '0) act_off <= bus.offset_i;
            bus.dat_valid_o <= s1_valid;
            bus.frame_o <= s1_valid && s1_last;
            bus.clip_o <= s1_valid && s1_en && sat_clip;
            if (s1_valid) bus.dat_o <= s1_en ? sat_dat : s1_dat;
        end
    end

`ifdef LAB_PEDSUB_CLIP_COUNT_EN
    logic [15:0] clip_cnt, clip_nxt;
    assign clip_nxt = clip_cnt + 16'(s1_en && sat_clip && !(&clip_cnt));

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            clip_cnt <= '0;
            bus.clip_count_o <= '0;
        end else if (s1_valid) begin
            clip_cnt <= s1_last ? '0 : clip_nxt;
            if (s1_last) bus.clip_count_o <= clip_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_lab_pedestal_subtract.sv
// tb_lab_pedestal_subtract: random and directed stimulus checked against a per-sample arithmetic reference model.
module tb_lab_pedestal_subtract;
    import lab_pkg::*;

    typedef struct {
        int due;
        int dat;
        bit clip;
        bit frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ped_sum [WINDOW];
    exp_t q [$];
    exp_t e_now;
    int m_adr = 0;
    int m_off = 2048;
    int m_cc = 0;
    int m_cc_out = 0;

    always #5 clk = ~clk;

    lab_pedestal_subtract_if bus ();
    lab_pedestal_subtract dut (.sys_clk_i(clk), .rst_i(rst), .bus(bus));

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.ped_en_o) bus.ped_dat_i <= sum_t'(ped_sum[bus.ped_adr_o]);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input bit wr, input int s, input bit arst, input bit en, input int off);
        int d;
        bit c;
        @(posedge clk);
        #1;
        bus.lab_wr_i = wr;
        bus.lab_dat_i = sample_t'(s);
        bus.addr_rst_i = arst;
        bus.pedsub_en_i = en;
        bus.offset_i = sample_t'(off);
        if (arst) m_adr = 0;
        #1;
        check("ped_en", 32'(bus.ped_en_o), 32'(wr));
        check("ped_adr", 32'(bus.ped_adr_o), m_adr);
        if (wr) begin
            if (m_adr == 0) m_off = off;
            d = s - ((ped_sum[m_adr] >> PED_SHIFT) % 8192) + m_off;
            c = en && (d < 0 || d > 4095);
            d = !en ? s : (d < 0 ? 0 : (d > 4095 ? 4095 : d));
            q.push_back('{cyc + 2, d, c, m_adr == WINDOW - 1});
            m_adr = (m_adr + 1) % WINDOW;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 1, 2048);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            e_now = q.pop_front();
            check("valid", 32'(bus.dat_valid_o), 1);
            check("dat", 32'(bus.dat_o), e_now.dat);
            check("clip", 32'(bus.clip_o), 32'(e_now.clip));
            check("frame", 32'(bus.frame_o), 32'(e_now.frame));
`ifdef LAB_PEDSUB_CLIP_COUNT_EN
            if (e_now.clip && m_cc < 65535) m_cc++;
            if (e_now.frame) begin
                m_cc_out = m_cc;
                m_cc = 0;
            end
            check("clip_count", 32'(bus.clip_count_o), m_cc_out);
`endif
        end else begin
            check("idle_valid", 32'(bus.dat_valid_o), 0);
            check("idle_frame", 32'(bus.frame_o), 0);
            check("idle_clip", 32'(bus.clip_o), 0);
        end
    end

    initial begin
        bus.lab_wr_i = 1'b0;
        bus.lab_dat_i = '0;
        bus.addr_rst_i = 1'b0;
        bus.pedsub_en_i = 1'b1;
        bus.offset_i = 12'd2048;
        foreach (ped_sum[i]) ped_sum[i] = 1600;
        repeat (3) @(posedge clk);
        #2;
        check("rst_dat", 32'(bus.dat_o), 0);
        check("rst_adr", 32'(bus.ped_adr_o), 0);
`ifdef LAB_PEDSUB_CLIP_COUNT_EN
        check("rst_clip_count", 32'(bus.clip_count_o), 0);
`endif
        rst = 1'b0;
        // pedestal 100, offset 2048: 500 -> 2448
        drive(1, 500, 0, 1, 2048);
        idle(3);
        drive(1, 0, 1, 1, 0);
        idle(1);
        ped_sum[0] = 0;
        drive(1, 4095, 1, 1, 2048);
        idle(1);
        ped_sum[0] = 1600;
        drive(1, 1234, 1, 0, 2048);
        idle(3);
        // addr_rst_i coincident with a strobe at address 37
        drive(1, $urandom_range(0, 4095), 1, 1, 2048);
        repeat (36) drive(1, $urandom_range(0, 4095), 0, 1, 2048);
        drive(1, $urandom_range(0, 4095), 1, 1, 2048);
        drive(1, $urandom_range(0, 4095), 0, 1, 2048);
        drive(0, 0, 1, 1, 2048);
        drive(1, 700, 0, 1, 2048);
        idle(3);
        foreach (ped_sum[i])
            ped_sum[i] = (i % 2 == 1) ? int'($urandom & 32'h07FF_FFFF)
                                      : 16 * int'($urandom_range(0, 4095)) + int'($urandom_range(0, 15));
        // 4097 back-to-back strobes, offset_i changes to 1000 at address 10
        drive(1, $urandom_range(0, 4095), 1, $urandom_range(0, 3) != 0, 2048);
        for (int k = 1; k <= 4096; k++)
            drive(1, $urandom_range(0, 4095), 0, $urandom_range(0, 3) != 0, k >= 10 ? 1000 : 2048);
        idle(3);
        foreach (ped_sum[i]) ped_sum[i] = 1600;
        // window with gaps and exactly three clipped samples
        drive(1, $urandom_range(0, 2000), 1, 1, 2048);
        for (int k = 1; k < WINDOW; k++) begin
            if ($urandom_range(0, 9) == 0) idle(1);
            drive(1, (k == 100 || k == 2000 || k == 4095) ? 4095 : int'($urandom_range(0, 2000)), 0, 1, 2048);
        end
        idle(3);
`ifdef LAB_PEDSUB_CLIP_COUNT_EN
        check("clip_count_3", 32'(bus.clip_count_o), 3);
`endif
        // reset with two samples in flight
        drive(1, 321, 0, 1, 2048);
        drive(1, 654, 0, 1, 2048);
        #1;
        bus.lab_wr_i = 1'b0;
        rst = 1'b1;
        q.delete();
        m_adr = 0;
        m_cc = 0;
        m_cc_out = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        drive(1, 900, 0, 1, 2048);
        idle(5);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
